fifo_byte_packer_rd: RTL

//   Read-side engine for the 8-bit register FIFO (IP_RegFifo family). Pops bytes from the

---
 rtl/fifo_pack_pkg.sv | 30 +++
 rtl/fifo_byte_packer_rd_if.sv | 33 +++
 rtl/pack_idle_timer.sv | 39 +++
 rtl/fifo_byte_packer_rd.sv | 128 ++++++++++++
 4 files changed

// File: rtl/fifo_pack_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pack_pkg
//   Shared definitions for the FIFO read-side byte packer: geometry constants,
//   the packer state type and the lane-mask helper.
//   No ports (package).
// ---------------------------------------------------------------------------
package fifo_pack_pkg;

  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 4;   // only supported value
  localparam int WORD_W         = BYTE_W * BYTES_PER_WORD;
  localparam int CNT_W          = 16;
  localparam int IDX_W          = 2;   // lane index width
  localparam int TIMER_W        = 8;   // idle timer / timeout width

  typedef enum logic {
    ST_FILL,
    ST_HOLD
  } packState_t;

  // Byte-enable mask for a word holding fillCount bytes packed from lane 0.
  function automatic logic [BYTES_PER_WORD-1:0] laneMask(input logic [IDX_W:0] fillCount);
    logic [BYTES_PER_WORD-1:0] mask;
    for (int k = 0; k < BYTES_PER_WORD; k++) begin
      mask[k] = (k < int'(fillCount));
    end
    return mask;
  endfunction

endpackage

// File: rtl/fifo_byte_packer_rd_if.sv
// ---------------------------------------------------------------------------
// fifo_byte_packer_rd_if
//   Bundles the packer's FIFO read port, control inputs and word stream.
//   master : the packer (drives fifoPop and the word stream)
//   slave  : the surrounding FIFO / DMA side
//   Signals: fifoEmpty, fifoData, fifoPop, flush, timeoutCycles,
//            wordData, wordByteEn, wordValid, wordReady, wordsSent
// ---------------------------------------------------------------------------
interface fifo_byte_packer_rd_if;
  import fifo_pack_pkg::*;

  logic                      fifoEmpty;
  logic [BYTE_W-1:0]         fifoData;
  logic                      fifoPop;
  logic                      flush;
  logic [TIMER_W-1:0]        timeoutCycles;
  logic [WORD_W-1:0]         wordData;
  logic [BYTES_PER_WORD-1:0] wordByteEn;
  logic                      wordValid;
  logic                      wordReady;
  logic [CNT_W-1:0]          wordsSent;

  modport master (
    input  fifoEmpty, fifoData, flush, timeoutCycles, wordReady,
    output fifoPop, wordData, wordByteEn, wordValid, wordsSent
  );

  modport slave (
    output fifoEmpty, fifoData, flush, timeoutCycles, wordReady,
    input  fifoPop, wordData, wordByteEn, wordValid, wordsSent
  );

endinterface

// File: rtl/pack_idle_timer.sv
// ---------------------------------------------------------------------------
// pack_idle_timer
//   Saturating idle-cycle counter for the packer's auto-flush.
//   clockCore  in  core clock
//   resetCore  in  synchronous reset, active-high
//   clear      in  zero the counter (wins over enable)
//   enable     in  count this cycle
//   threshold  in  idle cycles before expiry; 0 disables expiry
//   expire     out high for the idle cycle that completes the threshold
// ---------------------------------------------------------------------------
module pack_idle_timer
  import fifo_pack_pkg::*;
(
  input  logic               clockCore,
  input  logic               resetCore,
  input  logic               clear,
  input  logic               enable,
  input  logic [TIMER_W-1:0] threshold,
  output logic               expire
);

  logic [TIMER_W-1:0] count;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clockCore) begin
    if (resetCore || clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + TIMER_W'(1);
    end
  end

  // Comparing against threshold-1 makes the word leave on the edge that ends
  // the threshold-th idle cycle. Threshold is read live, so a change applies
  // on the next compare.
  assign expire = enable && (threshold != '0) && (count == threshold - TIMER_W'(1));

endmodule

// File: rtl/fifo_byte_packer_rd.sv
// ---------------------------------------------------------------------------
// fifo_byte_packer_rd
//   Pops bytes from a show-ahead 8-bit FIFO and packs them little-endian into
//   32-bit words on a valid/ready stream. Partial words leave on flush or on
//   an idle timeout.
//   clockCore  in  core clock
//   resetCore  in  synchronous reset, active-high
//   bus        fifo_byte_packer_rd_if.master:
//                fifoEmpty/fifoData in, fifoPop out (FIFO read port)
//                flush, timeoutCycles in (partial-word control)
//                wordData/wordByteEn/wordValid out, wordReady in (stream)
//                wordsSent out (completed handshakes, wraps)
// ---------------------------------------------------------------------------
module fifo_byte_packer_rd
  import fifo_pack_pkg::*;
(
  input  logic                  clockCore,
  input  logic                  resetCore,
  fifo_byte_packer_rd_if.master bus
);

  packState_t                state, stateNext;
  logic [IDX_W-1:0]          idx, idxNext;
  logic [WORD_W-1:0]         acc, accNext;
  logic [BYTES_PER_WORD-1:0] byteEn, byteEnNext;
  logic [CNT_W-1:0]          sent, sentNext;

  logic             canAccept;
  logic             pop;
  logic             handshake;
  logic [IDX_W:0]   fillCount;    // bytes in the word after this cycle's pop
  logic             flushReq;
  logic             timerEnable;
  logic             timerClear;
  logic             timerExpire;

  // In HOLD a pop is only allowed in the handshake cycle, so the popped byte
  // can start the next word without a bubble.
  assign canAccept   = (state == ST_FILL) || bus.wordReady;
  assign pop         = canAccept && !bus.fifoEmpty && !resetCore;
  assign handshake   = (state == ST_HOLD) && bus.wordReady;
  assign fillCount   = {1'b0, idx} + {{IDX_W{1'b0}}, pop};
  assign timerEnable = (state == ST_FILL) && (idx != '0) && !pop;
  assign flushReq    = bus.flush || timerExpire;
  assign timerClear  = pop || (stateNext != ST_FILL);

  pack_idle_timer u_timer (
    .clockCore (clockCore),
    .resetCore (resetCore),
    .clear     (timerClear),
    .enable    (timerEnable),
    .threshold (bus.timeoutCycles),
    .expire    (timerExpire)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    stateNext  = state;
    idxNext    = idx;
    accNext    = acc;
    byteEnNext = byteEn;
    sentNext   = sent;

    unique case (state)
      ST_FILL: begin
        for (int k = 0; k < BYTES_PER_WORD; k++) begin
          if (pop && (idx == IDX_W'(k))) begin
            accNext[k*BYTE_W +: BYTE_W] = bus.fifoData;
          end
        end
        // A pop filling the last lane is a full word even if flush is also up.
        if (fillCount == (IDX_W+1)'(BYTES_PER_WORD)) begin
          stateNext  = ST_HOLD;
          idxNext    = '0;
          byteEnNext = '1;
        end else if (flushReq && (fillCount != '0)) begin
          stateNext  = ST_HOLD;
          idxNext    = '0;
          byteEnNext = laneMask(fillCount);
        end else begin
          idxNext = fillCount[IDX_W-1:0];
        end
      end

      ST_HOLD: begin
        if (handshake) begin
          stateNext  = ST_FILL;
          sentNext   = sent + CNT_W'(1);
          byteEnNext = '0;
          accNext    = '0;
          idxNext    = '0;
          if (pop) begin
            accNext[BYTE_W-1:0] = bus.fifoData;
            idxNext             = IDX_W'(1);
          end
        end
      end

      default: stateNext = ST_FILL;
    endcase
  end

  always_ff @(posedge clockCore) begin
    if (resetCore) begin
      state  <= ST_FILL;
      idx    <= '0;
      acc    <= '0;
      byteEn <= '0;
      sent   <= '0;
    end else begin
      state  <= stateNext;
      idx    <= idxNext;
      acc    <= accNext;
      byteEn <= byteEnNext;
      sent   <= sentNext;
    end
  end

  // The accumulator doubles as the output register: it is frozen in HOLD and
  // unfilled lanes are still zero when a partial word is emitted.
  assign bus.fifoPop    = pop;
  assign bus.wordData   = acc;
  assign bus.wordByteEn = byteEn;
  assign bus.wordValid  = (state == ST_HOLD);
  assign bus.wordsSent  = sent;

endmodule
